// File: rtl/cdr_loop_filter.sv
// Second-order CDR loop filter: integrates phase-detector votes into phase steps,
// trims the symbol period after persistent one-directional stepping, and flags lock.
module cdr_loop_filter #(
    parameter int unsigned VOTE_TH  = 4,
    parameter int unsigned FREQ_TH  = 3,
    parameter int unsigned NB_P_NOM = 25,
    parameter int unsigned NB_P_MIN = 23,
    parameter int unsigned NB_P_MAX = 27,
    parameter int unsigned LOCK_TH  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_valid,
    input  logic       i_T,
    input  logic       i_E,
    output logic [1:0] o_cnt_d,
    output logic [5:0] o_nb_P,
    output logic       o_step_up,
    output logic       o_step_dn,
    output logic       o_lock
);

    localparam int unsigned AW = $clog2(VOTE_TH) + 2;
    localparam int unsigned RW = $clog2(FREQ_TH + 1);
    localparam int unsigned LW = $clog2(LOCK_TH + 1);

    localparam logic signed [AW-1:0] AccOne = AW'(1);
    localparam logic signed [AW-1:0] AccMax = AW'(VOTE_TH);
    localparam logic signed [AW-1:0] AccMin = -AccMax;
    localparam logic [RW-1:0]        RunTh  = RW'(FREQ_TH);
    localparam logic [LW-1:0]        LockTh = LW'(LOCK_TH);
    localparam logic [5:0]           NbNom  = 6'(NB_P_NOM);
    localparam logic [5:0]           NbMin  = 6'(NB_P_MIN);
    localparam logic [5:0]           NbMax  = 6'(NB_P_MAX);

    typedef enum logic [0:0] {StAcq, StLocked} state_e;

    state_e                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d, acc_inc;
    logic [1:0]             cnt_q, cnt_d;
    logic [5:0]             nb_q, nb_d;
    logic [RW-1:0]          run_q, run_d, run_inc;
    logic                   run_dir_q, run_dir_d;
    logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
    logic                   up_q, up_d, dn_q, dn_d;
    logic                   vote, step;

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        nb_d       = nb_q;
        run_d      = run_q;
        run_dir_d  = run_dir_q;
        lock_cnt_d = lock_cnt_q;
        state_d    = state_q;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        run_inc    = '0;

        vote    = i_valid & i_T;
        acc_inc = i_E ? (acc_q + AccOne) : (acc_q - AccOne);

        // Reaching the threshold fires a step and empties the accumulator.
        if (vote) begin
            if (acc_inc == AccMax) begin
                up_d  = 1'b1;
                acc_d = '0;
                cnt_d = cnt_q + 2'd1;
            end else if (acc_inc == AccMin) begin
                dn_d  = 1'b1;
                acc_d = '0;
                cnt_d = cnt_q - 2'd1;
            end else begin
                acc_d = acc_inc;
            end
        end
        step = up_d | dn_d;

        if (step) begin
            run_inc   = (up_d == run_dir_q) ? (run_q + RW'(1)) : RW'(1);
            run_dir_d = up_d;
            run_d     = run_inc;
            if (run_inc == RunTh) begin
                run_d = '0;
                // A clamped adjustment is dropped, but the run still restarts.
                if (up_d && nb_q != NbMax) begin
                    nb_d = nb_q + 6'd1;
                end else if (dn_d && nb_q != NbMin) begin
                    nb_d = nb_q - 6'd1;
                end
            end
        end

        unique case (state_q)
            StAcq: begin
                if (step) begin
                    lock_cnt_d = '0;
                end else if (vote && lock_cnt_q != LockTh) begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                    if (lock_cnt_d == LockTh) state_d = StLocked;
                end
            end
            StLocked: begin
                if (step) begin
                    lock_cnt_d = '0;
                    state_d    = StAcq;
                end
            end
            default: state_d = StAcq;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StAcq;
            acc_q      <= '0;
            cnt_q      <= '0;
            nb_q       <= NbNom;
            run_q      <= '0;
            run_dir_q  <= 1'b0;
            lock_cnt_q <= '0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
        end else if (i_clr) begin
            state_q    <= StAcq;
            acc_q      <= '0;
            cnt_q      <= '0;
            nb_q       <= NbNom;
            run_q      <= '0;
            run_dir_q  <= 1'b0;
            lock_cnt_q <= '0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            nb_q       <= nb_d;
            run_q      <= run_d;
            run_dir_q  <= run_dir_d;
            lock_cnt_q <= lock_cnt_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
        end
    end

    assign o_cnt_d   = cnt_q;
    assign o_nb_P    = nb_q;
    assign o_step_up = up_q;
    assign o_step_dn = dn_q;
    assign o_lock    = (state_q == StLocked);

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Directed self-checking bench for cdr_loop_filter with hand-computed expectations.
module tb_cdr_loop_filter;

    logic       i_clk;
    logic       i_rst;
    logic       i_clr;
    logic       i_valid;
    logic       i_T;
    logic       i_E;
    logic [1:0] o_cnt_d;
    logic [5:0] o_nb_P;
    logic       o_step_up;
    logic       o_step_dn;
    logic       o_lock;

    int n_checks = 0;
    int n_errors = 0;

    cdr_loop_filter dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_clr),
        .i_valid   (i_valid),
        .i_T       (i_T),
        .i_E       (i_E),
        .o_cnt_d   (o_cnt_d),
        .o_nb_P    (o_nb_P),
        .o_step_up (o_step_up),
        .o_step_dn (o_step_dn),
        .o_lock    (o_lock)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // One-cycle strobe; returns 1 time unit after the sampling edge.
    task automatic vote(input logic t, input logic e, input logic clr);
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_T     = t;
        i_E     = e;
        i_clr   = clr;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_T     = 1'b0;
        i_E     = 1'b0;
        i_clr   = 1'b0;
    endtask

    task automatic clear();
        @(posedge i_clk);
        #1 i_clr = 1'b1;
        @(posedge i_clk);
        #1 i_clr = 1'b0;
    endtask

    // Four same-direction votes: quiet for three, step on the fourth, pulse lasts one cycle.
    task automatic do_step(input logic up, input logic [1:0] exp_cnt, input logic [5:0] exp_nb);
        for (int i = 0; i < 3; i++) begin
            vote(1'b1, up, 1'b0);
            check("pre_step_quiet", {31'd0, o_step_up | o_step_dn}, 32'd0);
        end
        vote(1'b1, up, 1'b0);
        check("step_up", {31'd0, o_step_up}, {31'd0, up});
        check("step_dn", {31'd0, o_step_dn}, {31'd0, ~up});
        check("cnt_d", {30'd0, o_cnt_d}, {30'd0, exp_cnt});
        check("nb_P", {26'd0, o_nb_P}, {26'd0, exp_nb});
        @(posedge i_clk);
        #1;
        check("pulse_end", {31'd0, o_step_up | o_step_dn}, 32'd0);
    endtask

    initial begin
        i_rst   = 1'b0;
        i_clr   = 1'b0;
        i_valid = 1'b0;
        i_T     = 1'b0;
        i_E     = 1'b0;
        #23;
        check("rst_cnt", {30'd0, o_cnt_d}, 32'd0);
        check("rst_nb", {26'd0, o_nb_P}, 32'd25);
        check("rst_lock", {31'd0, o_lock}, 32'd0);
        i_rst = 1'b1;

        // No-transition strobes change nothing.
        for (int i = 0; i < 10; i++) begin
            vote(1'b0, 1'b1, 1'b0);
            check("idle_pulse", {31'd0, o_step_up | o_step_dn}, 32'd0);
        end
        check("idle_cnt", {30'd0, o_cnt_d}, 32'd0);
        check("idle_nb", {26'd0, o_nb_P}, 32'd25);
        check("idle_lock", {31'd0, o_lock}, 32'd0);

        // First up-step, then three votes short of another.
        do_step(1'b1, 2'd1, 6'd25);
        for (int i = 0; i < 3; i++) begin
            vote(1'b1, 1'b1, 1'b0);
            check("acc_cleared", {31'd0, o_step_up | o_step_dn}, 32'd0);
        end
        check("cnt_hold", {30'd0, o_cnt_d}, 32'd1);

        // Alternating votes: no steps, lock after the 16th transition.
        clear();
        for (int i = 0; i < 50; i++) begin
            vote(1'b1, (i % 2 == 0), 1'b0);
            check("alt_no_step", {31'd0, o_step_up | o_step_dn}, 32'd0);
            if (i == 14) check("lock_at_15", {31'd0, o_lock}, 32'd0);
            if (i == 15) check("lock_at_16", {31'd0, o_lock}, 32'd1);
        end
        check("alt_lock", {31'd0, o_lock}, 32'd1);

        // Wrap-around and period trimming up to the upper clamp.
        clear();
        do_step(1'b0, 2'd3, 6'd25);
        do_step(1'b1, 2'd0, 6'd25);
        do_step(1'b1, 2'd1, 6'd25);
        do_step(1'b1, 2'd2, 6'd26);
        do_step(1'b1, 2'd3, 6'd26);
        do_step(1'b1, 2'd0, 6'd26);
        do_step(1'b1, 2'd1, 6'd27);
        do_step(1'b1, 2'd2, 6'd27);
        do_step(1'b1, 2'd3, 6'd27);
        do_step(1'b1, 2'd0, 6'd27);
        do_step(1'b1, 2'd1, 6'd27);
        do_step(1'b1, 2'd2, 6'd27);

        // Clear coincident with the fourth vote wins.
        clear();
        for (int i = 0; i < 3; i++) vote(1'b1, 1'b1, 1'b0);
        vote(1'b1, 1'b1, 1'b1);
        check("clr_no_up", {31'd0, o_step_up}, 32'd0);
        check("clr_no_dn", {31'd0, o_step_dn}, 32'd0);
        check("clr_cnt", {30'd0, o_cnt_d}, 32'd0);
        check("clr_nb", {26'd0, o_nb_P}, 32'd25);
        check("clr_lock", {31'd0, o_lock}, 32'd0);
        do_step(1'b1, 2'd1, 6'd25);

        // Lock, then direction reversal; a step drops lock.
        clear();
        for (int i = 0; i < 16; i++) vote(1'b1, (i % 2 == 0), 1'b0);
        check("pre_lock", {31'd0, o_lock}, 32'd1);
        do_step(1'b1, 2'd1, 6'd25);
        check("lock_drop", {31'd0, o_lock}, 32'd0);
        do_step(1'b1, 2'd2, 6'd25);
        do_step(1'b0, 2'd1, 6'd25);
        do_step(1'b0, 2'd0, 6'd25);
        do_step(1'b0, 2'd3, 6'd24);

        // Asynchronous reset between edges.
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        check("arst_cnt", {30'd0, o_cnt_d}, 32'd0);
        check("arst_nb", {26'd0, o_nb_P}, 32'd25);
        check("arst_pulse", {31'd0, o_step_up | o_step_dn}, 32'd0);
        check("arst_lock", {31'd0, o_lock}, 32'd0);
        #10 i_rst = 1'b1;
        do_step(1'b1, 2'd1, 6'd25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
